rx_frame_ua: RTL and testbench

- Receives the measurement frames produced by the team's UART frame transmitter and recovers the 32-bit value: header 0xAA, four payload bytes MSB-first, trailer 0xBB, each byte 8N1, LSB first.
- Sits directly downstream of the transmitter: it is the loopback checker in simulation and the FPGA-side receiver on a second board.
- Reports good frames with a one-cycle strobe and bad frames with an error strobe.

---
 rtl/rx_frame_ua.sv | 201 ++++++++++++++++++++
 tb/tb_rx_frame_ua.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_ua.sv
// rx_frame_ua: UART receiver for measurement frames.
// A frame is header 0xAA, four payload bytes MSB-first and trailer 0xBB.
// Each byte is 8N1 and sent LSB first.
// Good frames raise a one-cycle frame_valid and update frame_value.
// Aborted frames raise a one-cycle frame_err.
`timescale 1ns/1ps
module rx_frame_ua #(
    parameter int CLKS_PER_BIT = 52,
    parameter int TIMEOUT_CLKS = 20*CLKS_PER_BIT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    output logic [31:0] frame_value,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        busy
);

    // Byte FSM states
    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    // Frame FSM states
    localparam logic [1:0] F_HDR = 2'd0;
    localparam logic [1:0] F_PAY = 2'd1;
    localparam logic [1:0] F_TRL = 2'd2;

    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT/2 - 1);
    localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);

    localparam int GAP_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TIMEOUT_CLKS);

    logic             rx_meta_reg;
    logic             rx_s_reg;

    logic [1:0]       rstate_reg;
    logic [15:0]      cnt_reg;
    logic [2:0]       idx_reg;
    logic [7:0]       shift_reg;
    logic [7:0]       byte_data_reg;
    logic             byte_valid_reg;
    logic             byte_ferr_reg;

    logic [1:0]       fstate_reg;
    logic [1:0]       k_reg;
    logic [31:0]      shreg_reg;
    logic [31:0]      frame_value_reg;
    logic             frame_valid_reg;
    logic             frame_err_reg;
    logic [GAP_W-1:0] gap_reg;

    // Two-flop synchronizer for the asynchronous serial line; resets to idle (1)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= uart_rx;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    // Byte receiver: start-bit qualification at mid-bit, then 8 data bits and stop bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rstate_reg     <= R_IDLE;
            cnt_reg        <= '0;
            idx_reg        <= '0;
            shift_reg      <= '0;
            byte_data_reg  <= '0;
            byte_valid_reg <= 1'b0;
            byte_ferr_reg  <= 1'b0;
        end else begin
            byte_valid_reg <= 1'b0;
            byte_ferr_reg  <= 1'b0;
            case (rstate_reg)
                R_IDLE: begin
                    if (!rx_s_reg) begin
                        rstate_reg <= R_START;
                        cnt_reg    <= '0;
                    end
                end
                R_START: begin
                    if (cnt_reg == HALF_M1) begin
                        cnt_reg <= '0;
                        idx_reg <= '0;
                        // Line back high at mid start bit means a glitch
                        rstate_reg <= rx_s_reg ? R_IDLE : R_DATA;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                R_DATA: begin
                    if (cnt_reg == BIT_M1) begin
                        cnt_reg   <= '0;
                        shift_reg <= {rx_s_reg, shift_reg[7:1]};
                        if (idx_reg == 3'd7) begin
                            rstate_reg <= R_STOP;
                        end else begin
                            idx_reg <= idx_reg + 3'd1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                R_STOP: begin
                    if (cnt_reg == BIT_M1) begin
                        cnt_reg <= '0;
                        if (rx_s_reg) begin
                            byte_data_reg  <= shift_reg;
                            byte_valid_reg <= 1'b1;
                        end else begin
                            byte_ferr_reg <= 1'b1;
                        end
                        // Return to idle at mid stop bit so a start one cycle later is caught
                        rstate_reg <= R_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                default: rstate_reg <= R_IDLE;
            endcase
        end
    end

    // Frame assembler: header hunt, payload shift, trailer check, abort on framing error or gap timeout
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fstate_reg      <= F_HDR;
            k_reg           <= '0;
            shreg_reg       <= '0;
            frame_value_reg <= '0;
            frame_valid_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
            gap_reg         <= '0;
        end else begin
            frame_valid_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
            if (byte_valid_reg) begin
                gap_reg <= '0;
                case (fstate_reg)
                    F_HDR: begin
                        // Non-header bytes are dropped while hunting
                        if (byte_data_reg == 8'hAA) begin
                            fstate_reg <= F_PAY;
                            k_reg      <= '0;
                        end
                    end
                    F_PAY: begin
                        // 0xAA inside the payload is data, not a resync point
                        shreg_reg <= {shreg_reg[23:0], byte_data_reg};
                        if (k_reg == 2'd3) begin
                            fstate_reg <= F_TRL;
                        end else begin
                            k_reg <= k_reg + 2'd1;
                        end
                    end
                    F_TRL: begin
                        if (byte_data_reg == 8'hBB) begin
                            frame_value_reg <= shreg_reg;
                            frame_valid_reg <= 1'b1;
                        end else begin
                            frame_err_reg <= 1'b1;
                        end
                        // A bad trailer byte is consumed, never reused as a header
                        fstate_reg <= F_HDR;
                    end
                    default: fstate_reg <= F_HDR;
                endcase
            end else if (byte_ferr_reg) begin
                gap_reg <= '0;
                if (fstate_reg != F_HDR) begin
                    frame_err_reg <= 1'b1;
                    fstate_reg    <= F_HDR;
                end
            end else if (fstate_reg != F_HDR) begin
                if (gap_reg == GAP_MAX) begin
                    frame_err_reg <= 1'b1;
                    fstate_reg    <= F_HDR;
                    gap_reg       <= '0;
                end else begin
                    gap_reg <= gap_reg + 1'b1;
                end
            end
        end
    end

    assign byte_data   = byte_data_reg;
    assign byte_valid  = byte_valid_reg;
    assign frame_value = frame_value_reg;
    assign frame_valid = frame_valid_reg;
    assign frame_err   = frame_err_reg;
    assign busy        = (rstate_reg != R_IDLE) || (fstate_reg != F_HDR);

endmodule

// File: tb/tb_rx_frame_ua.sv
// Testbench for rx_frame_ua.
// A frame-level model predicts every strobe and the cycle on which it appears.
// A compare process checks the DUT against that model on every cycle.
`timescale 1ns/1ps
module tb_rx_frame_ua;

    localparam int CPB = 52;
    localparam int TO  = 20*CPB;
    // Line start edge to stop-bit sample edge:
    // 2-flop sync, 1 edge to see the start, half a bit to mid start, 9 bits to mid stop
    localparam int STOP_LAT = 3 + CPB/2 + 9*CPB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic [31:0] frame_value;
    logic        frame_valid;
    logic        frame_err;
    logic        busy;

    rx_frame_ua #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
        .byte_data(byte_data), .byte_valid(byte_valid),
        .frame_value(frame_value), .frame_valid(frame_valid),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [7:0] data; } bv_t;
    typedef struct { int cyc; bit good; logic [31:0] value; } fr_t;

    bv_t         bvq[$];
    fr_t         frq[$];
    logic [7:0]  pend[$];
    logic [31:0] model_value = '0;
    int          last_evt = 0;
    bit          checking = 1'b0;
    int          tests = 0;
    int          fails = 0;
    int          n_bv = 0, n_fv = 0, n_fe = 0;

    // Frame-level model: fed with each byte as it starts on the line
    function automatic void model_byte(input logic [7:0] d, input bit stop_ok, input int c0);
        int t_evt;
        t_evt = c0 + STOP_LAT;
        last_evt = t_evt;
        if (stop_ok) begin
            bvq.push_back('{cyc: t_evt, data: d});
            if (pend.size() == 0) begin
                if (d == 8'hAA) pend.push_back(d);
            end else if (pend.size() < 5) begin
                pend.push_back(d);
            end else begin
                if (d == 8'hBB)
                    frq.push_back('{cyc: t_evt + 1, good: 1'b1,
                                    value: {pend[1], pend[2], pend[3], pend[4]}});
                else
                    frq.push_back('{cyc: t_evt + 1, good: 1'b0, value: 32'h0});
                pend.delete();
            end
        end else if (pend.size() != 0) begin
            frq.push_back('{cyc: t_evt + 1, good: 1'b0, value: 32'h0});
            pend.delete();
        end
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Per-cycle comparison of the strobes and frame value against the model
    always @(negedge clk) begin
        bit exp_bv, exp_fv, exp_fe;
        if (checking) begin
            exp_bv = (bvq.size() > 0) && (bvq[0].cyc == cyc);
            exp_fv = (frq.size() > 0) && (frq[0].cyc == cyc) && frq[0].good;
            exp_fe = (frq.size() > 0) && (frq[0].cyc == cyc) && !frq[0].good;
            if (byte_valid === 1'b1) n_bv++;
            if (frame_valid === 1'b1) n_fv++;
            if (frame_err === 1'b1) n_fe++;

            if (exp_bv || byte_valid !== 1'b0) begin
                tests++;
                if (byte_valid !== exp_bv) begin
                    fails++;
                    $display("FAIL byte_valid cyc=%0d: got %b, want %b", cyc, byte_valid, exp_bv);
                end
            end
            if (exp_bv) begin
                tests++;
                if (byte_data !== bvq[0].data) begin
                    fails++;
                    $display("FAIL byte_data cyc=%0d: got %h, want %h", cyc, byte_data, bvq[0].data);
                end
                void'(bvq.pop_front());
            end
            if (exp_fv || frame_valid !== 1'b0) begin
                tests++;
                if (frame_valid !== exp_fv) begin
                    fails++;
                    $display("FAIL frame_valid cyc=%0d: got %b, want %b", cyc, frame_valid, exp_fv);
                end
            end
            if (exp_fe || frame_err !== 1'b0) begin
                tests++;
                if (frame_err !== exp_fe) begin
                    fails++;
                    $display("FAIL frame_err cyc=%0d: got %b, want %b", cyc, frame_err, exp_fe);
                end
            end
            if (exp_fv) model_value = frq[0].value;
            if (exp_fv || exp_fe) begin
                void'(frq.pop_front());
                tests++;
                if (frame_value !== model_value) begin
                    fails++;
                    $display("FAIL frame_value cyc=%0d: got %h, want %h", cyc, frame_value, model_value);
                end
            end
            if ((int'(byte_valid === 1'b1) + int'(frame_valid === 1'b1) + int'(frame_err === 1'b1)) > 1) begin
                tests++;
                fails++;
                $display("FAIL strobe_exclusive cyc=%0d: got bv=%b fv=%b fe=%b, want at most one",
                         cyc, byte_valid, frame_valid, frame_err);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        uart_rx = b;
        tick(CPB);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit stop_ok);
        model_byte(d, stop_ok, cyc);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_ok);
        uart_rx = 1'b1;
    endtask

    task automatic send_frame(input logic [31:0] v);
        send_byte(8'hAA, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(v[31-8*i -: 8], 1'b1);
        send_byte(8'hBB, 1'b1);
    endtask

    // Idle line; the model predicts a timeout abort if the gap runs out inside a frame
    task automatic idle(input int n);
        if (pend.size() != 0 && (last_evt + TO + 2) <= (cyc + n)) begin
            frq.push_back('{cyc: last_evt + TO + 2, good: 1'b0, value: 32'h0});
            pend.delete();
        end
        tick(n);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int bv0, fv0, fe0;

        // Reset state
        rst_n = 1'b0;
        tick(5);
        check("rst_byte_data", {24'h0, byte_data}, 32'h0);
        check("rst_byte_valid", {31'h0, byte_valid}, 32'h0);
        check("rst_frame_value", frame_value, 32'h0);
        check("rst_frame_valid", {31'h0, frame_valid}, 32'h0);
        check("rst_frame_err", {31'h0, frame_err}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        rst_n = 1'b1;
        checking = 1'b1;
        tick(20);

        // Basic good frame
        bv0 = n_bv; fv0 = n_fv; fe0 = n_fe;
        send_frame(32'h00000100);
        tick(5);
        check("f1_value", frame_value, 32'h00000100);
        check("f1_byte_count", n_bv - bv0, 6);
        check("f1_fv_count", n_fv - fv0, 1);
        check("f1_fe_count", n_fe - fe0, 0);

        // Leading junk, then back-to-back frames including 0xAA in the payload
        fe0 = n_fe;
        send_byte(8'h55, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_frame(32'h12345678);
        check("junk_value", frame_value, 32'h12345678);
        send_frame(32'hAA00AA01);
        check("aa_payload_value", frame_value, 32'hAA00AA01);
        check("junk_fe_count", n_fe - fe0, 0);

        // Bad trailer leaves the value untouched; next frame accepted
        send_frame(32'h12345678);
        fe0 = n_fe;
        send_byte(8'hAA, 1'b1);
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        send_byte(8'hBC, 1'b1);
        check("badtrl_fe_count", n_fe - fe0, 1);
        check("badtrl_value", frame_value, 32'h12345678);
        send_frame(32'h0BADF00D);
        check("after_badtrl_value", frame_value, 32'h0BADF00D);

        // Framing error on the third payload byte
        fe0 = n_fe;
        send_byte(8'hAA, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b0);
        idle(60);
        check("ferr_fe_count", n_fe - fe0, 1);
        check("ferr_value", frame_value, 32'h0BADF00D);
        send_frame(32'h0000002A);
        check("after_ferr_value", frame_value, 32'h0000002A);

        // Short low glitch on the idle line
        bv0 = n_bv;
        uart_rx = 1'b0;
        tick(10);
        uart_rx = 1'b1;
        tick(40);
        check("glitch_byte_count", n_bv - bv0, 0);
        check("glitch_busy", {31'h0, busy}, 32'h0);

        // Inter-byte timeout
        fe0 = n_fe;
        send_byte(8'hAA, 1'b1);
        send_byte(8'h12, 1'b1);
        idle(TO + 10);
        check("timeout_fe_count", n_fe - fe0, 1);
        check("timeout_busy", {31'h0, busy}, 32'h0);
        check("timeout_value", frame_value, 32'h0000002A);

        // Reset during the second payload byte
        send_byte(8'hAA, 1'b1);
        send_byte(8'h12, 1'b1);
        uart_rx = 1'b0;
        tick(CPB);
        drive_bit(1'b0);
        drive_bit(1'b0);
        bv0 = n_bv; fv0 = n_fv; fe0 = n_fe;
        rst_n = 1'b0;
        uart_rx = 1'b1;
        tick(1);
        pend.delete();
        model_value = '0;
        tick(2);
        check("midrst_byte_data", {24'h0, byte_data}, 32'h0);
        check("midrst_byte_valid", {31'h0, byte_valid}, 32'h0);
        check("midrst_frame_value", frame_value, 32'h0);
        check("midrst_frame_valid", {31'h0, frame_valid}, 32'h0);
        check("midrst_frame_err", {31'h0, frame_err}, 32'h0);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        rst_n = 1'b1;
        tick(600);
        check("midrst_strobes", (n_bv - bv0) + (n_fv - fv0) + (n_fe - fe0), 0);
        send_frame(32'hCAFEBABE);
        check("after_rst_value", frame_value, 32'hCAFEBABE);

        tick(10);
        check("model_drained", bvq.size() + frq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
